seq_alu: RTL and testbench

- Parametrised, handshaked, multi-cycle successor to the 64-bit combinational ALU.
- Sits between the register-read and writeback stages of the CPU datapath.
- Captures operands on a valid/ready handshake and produces a registered result plus per-operation flags.
- Adds an iterative shift-add multiply, a shift-left op, and an architectural NZVC flag register updated only when the instruction's set-flags bit is set.

---
 rtl/seq_alu.sv | 94 +++++++++
 tb/tb_seq_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked multi-cycle ALU with shift-add multiply and an architectural NZVC register
module seq_alu #(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       op_flags,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2*WIDTH-1:0] mcand, acc, acc_n;
  logic [WIDTH-1:0] mplier, bx, r;
  logic [WIDTH:0] sum, shl;
  logic [SHW-1:0] cnt;
  logic [3:0] nzvc;
  logic sf, sub, arith, v, c, hi;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign {negative, zero, overflow, carry_out} = nzvc;
  assign sub = cntrl == 3'b011;
  assign arith = sub || cntrl == 3'b010;
  assign bx = sub ? ~B : B;
  assign sum = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // bit WIDTH of the widened shift is the last bit pushed out of A
  assign shl = {1'b0, A} << B[SHW-1:0];
  assign r = cntrl == 3'b000 ? B :
             arith           ? sum[WIDTH-1:0] :
             cntrl == 3'b100 ? A & B :
             cntrl == 3'b101 ? A | B :
             cntrl == 3'b110 ? A ^ B : shl[WIDTH-1:0];
  assign v = arith && (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign c = arith ? sum[WIDTH] : cntrl == 3'b111 ? shl[WIDTH] : 1'b0;
  assign acc_n = mplier[0] ? acc + mcand : acc;
  assign hi = |acc_n[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      cnt <= '0;
      sf <= 1'b0;
      result <= '0;
      op_flags <= '0;
      nzvc <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sf <= set_flags;
          if (cntrl == 3'b001) begin
            mcand <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc <= '0;
            cnt <= '0;
            state <= BUSY;
          end else begin
            result <= r;
            op_flags <= {r[WIDTH-1], r == '0, v, c};
            state <= DONE;
          end
        end
        BUSY: begin
          acc <= acc_n;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + SHW'(1);
          if (&cnt) begin
            result <= acc_n[WIDTH-1:0];
            op_flags <= {acc_n[WIDTH-1], acc_n[WIDTH-1:0] == '0, hi, hi};
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          if (sf) nzvc <= op_flags;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors against a behavioural model of seq_alu, plus a WIDTH=8 instance
module tb_seq_alu;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0, set_flags = 0;
  logic [63:0] A = 0, B = 0;
  logic [2:0] cntrl = 0;
  logic in_ready, out_valid, negative, zero, overflow, carry_out;
  logic [63:0] result;
  logic [3:0] op_flags;
  logic in_valid8 = 0, out_ready8 = 0, set_flags8 = 0;
  logic [7:0] A8 = 0, B8 = 0;
  logic [2:0] cntrl8 = 0;
  logic in_ready8, out_valid8, n8, z8, v8, c8;
  logic [7:0] result8;
  logic [3:0] op_flags8;
  int checks = 0, errors = 0;
  logic [63:0] m_res;
  logic [3:0] m_flags, m_nzvc = 0;

  seq_alu #(.WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cntrl(cntrl), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .op_flags(op_flags),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .cntrl(cntrl8), .set_flags(set_flags8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .op_flags(op_flags8),
    .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    logic [127:0] p, w;
    logic [64:0] s, ss;
    logic [63:0] r;
    logic v, c;
    v = 0;
    c = 0;
    case (op)
      3'b000: r = b;
      3'b001: begin
        p = {64'b0, a} * {64'b0, b};
        r = p[63:0];
        v = |p[127:64];
        c = v;
      end
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        ss = {a[63], a} + {b[63], b};
        r = s[63:0];
        c = s[64];
        v = ss[64] != ss[63];
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        ss = {a[63], a} - {b[63], b};
        r = s[63:0];
        c = s[64];
        v = ss[64] != ss[63];
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: begin
        w = {64'b0, a} << b[5:0];
        r = w[63:0];
        c = w[64];
      end
    endcase
    m_res = r;
    m_flags = {r[63], r == 64'd0, v, c};
  endfunction

  always @(negedge clk)
    if (reset_n) begin
      chk("nzvc", {negative, zero, overflow, carry_out}, m_nzvc);
      if (out_valid) begin
        chk("result", result, m_res);
        chk("op_flags", op_flags, m_flags);
      end
    end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic sf, input int hold);
    int lat;
    model(a, b, op);
    chk("in_ready_idle", in_ready, 1);
    A = a;
    B = b;
    cntrl = op;
    set_flags = sf;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (op == 3'b001) begin
        in_valid = lat[0];
        A = 64'($urandom);
      end
      @(posedge clk);
      #1 lat++;
    end
    in_valid = 0;
    chk("latency", lat, op == 3'b001 ? 65 : 1);
    for (int i = 0; i < hold; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", result, m_res);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    if (sf) m_nzvc = m_flags;
    #1 out_ready = 0;
    chk("ack_out_valid", out_valid, 0);
    chk("ack_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_result", result, 0);
    chk("rst_op_flags", op_flags, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nzvc", {negative, zero, overflow, carry_out}, 0);
    reset_n = 1;
    @(posedge clk);
    #1;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1, 0);
    chk("pin_add_res", m_res, 64'h8000_0000_0000_0000);
    chk("pin_add_flags", m_flags, 4'b1010);
    chk("nzvc_add", {negative, zero, overflow, carry_out}, 4'b1010);
    issue(64'd5, 64'd5, 3'b011, 0, 0);
    chk("pin_sub_res", m_res, 0);
    chk("pin_sub_flags", m_flags, 4'b0101);
    chk("nzvc_sub_hold", {negative, zero, overflow, carry_out}, 4'b1010);
    A = 64'hFFFF;
    B = 64'd3;
    cntrl = 3'b001;
    set_flags = 1;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #2 reset_n = 0;
    m_nzvc = 0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_nzvc", {negative, zero, overflow, carry_out}, 0);
    #1 reset_n = 1;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("abandoned_mul", seen, 0);
    issue(64'h1_0000_0000, 64'h1_0000_0000, 3'b001, 0, 0);
    chk("pin_mul_res", m_res, 0);
    chk("pin_mul_flags", m_flags, 4'b0111);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1, 0);
    chk("pin_mul2_res", m_res, 1);
    chk("nzvc_mul2", {negative, zero, overflow, carry_out}, 4'b0011);
    issue(64'd3, 64'd5, 3'b001, 0, 0);
    chk("pin_mul3_res", m_res, 15);
    issue(64'h8000_0000_0000_0001, 64'd1, 3'b111, 0, 10);
    chk("pin_shl_res", m_res, 2);
    chk("pin_shl_flags", m_flags, 4'b0001);
    issue(64'h1234, 64'd0, 3'b111, 1, 0);
    chk("pin_shl0_flags", m_flags, 4'b0000);
    chk("nzvc_shl0", {negative, zero, overflow, carry_out}, 4'b0000);
    issue(64'd3, 64'd5, 3'b011, 1, 0);
    chk("nzvc_borrow", {negative, zero, overflow, carry_out}, 4'b1000);
    issue(64'h8000_0000_0000_0000, 64'd1, 3'b011, 1, 0);
    chk("nzvc_sub_ovf", {negative, zero, overflow, carry_out}, 4'b0011);
    issue(64'hF0F0, 64'h0FF0, 3'b100, 0, 0);
    issue(64'hF0F0, 64'h0FF0, 3'b101, 0, 0);
    issue(64'hF0F0, 64'h0FF0, 3'b110, 0, 2);
    issue(64'hDEAD, 64'd0, 3'b000, 1, 0);
    chk("nzvc_pass_zero", {negative, zero, overflow, carry_out}, 4'b0100);
    A8 = 8'hF0;
    B8 = 8'hFF;
    cntrl8 = 3'b110;
    in_valid8 = 1;
    @(posedge clk);
    #1 in_valid8 = 0;
    chk("w8_out_valid", out_valid8, 1);
    chk("w8_result", result8, 8'h0F);
    chk("w8_op_flags", op_flags8, 4'b0000);
    out_ready8 = 1;
    @(posedge clk);
    #1 out_ready8 = 0;
    chk("w8_in_ready", in_ready8, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
